world_map_addr_gen: RTL and testbench

Display-side address generator that feeds the world-map BRAM read port and the world-pixel delay stage behind it. It takes the display timing generator's pixel_row/pixel_column/video_on and produces the 14-bit world-map address {map_row, map_col} for each pixel. It uses step counters rather than dividers. It also delays video_on so it lines up with the 2-bit world pixel at the colorizer input.

---
 rtl/world_map_addr_gen_pkg.sv | 17 +
 rtl/world_map_addr_gen_if.sv | 40 ++++
 rtl/world_map_addr_gen_align_shift_reg.sv | 27 ++
 rtl/world_map_addr_gen.sv | 148 ++++++++++++++
 tb/tb_world_map_addr_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/world_map_addr_gen_pkg.sv
// Shared world-map constants and the 2-bit world pixel codes used by the display path.
// Screen coordinates are 11 bits; the map address is {map_row, map_col}, each half of MAP_ADDR_W.
package world_map_pkg;

  localparam int MAP_DIM     = 128;
  localparam int MAP_ADDR_W  = 14;
  localparam int WORLD_PIX_W = 2;
  localparam int PIX_COORD_W = 11;

  typedef enum logic [WORLD_PIX_W-1:0] {
    GROUND      = 2'd0,
    BLACK_LINE  = 2'd1,
    OBSTRUCTION = 2'd2,
    RESERVED    = 2'd3
  } world_pix_e;

endpackage

// File: rtl/world_map_addr_gen_if.sv
// Timing-generator inputs and address/alignment outputs of world_map_addr_gen.
// WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN adds the hsync/vsync inputs and their aligned copies.
interface world_map_addr_gen_if;
  import world_map_pkg::*;

  logic [PIX_COORD_W-1:0] pixel_row;
  logic [PIX_COORD_W-1:0] pixel_column;
  logic                   video_on;
  logic [MAP_ADDR_W-1:0]  vid_addr;
  logic                   out_of_map;
  logic                   video_on_aligned;

`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
  logic hsync_in;
  logic vsync_in;
  logic hsync_aligned;
  logic vsync_aligned;

  modport master (
    output pixel_row, pixel_column, video_on, hsync_in, vsync_in,
    input  vid_addr, out_of_map, video_on_aligned, hsync_aligned, vsync_aligned
  );

  modport slave (
    input  pixel_row, pixel_column, video_on, hsync_in, vsync_in,
    output vid_addr, out_of_map, video_on_aligned, hsync_aligned, vsync_aligned
  );
`else
  modport master (
    output pixel_row, pixel_column, video_on,
    input  vid_addr, out_of_map, video_on_aligned
  );

  modport slave (
    input  pixel_row, pixel_column, video_on,
    output vid_addr, out_of_map, video_on_aligned
  );
`endif

endinterface

// File: rtl/world_map_addr_gen_align_shift_reg.sv
// Fixed-depth delay line with a synchronous reset value; output is the input delayed DEPTH cycles.
// No flow control: one new sample is accepted every clock.
module align_shift_reg #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[DEPTH-1];

endmodule

// File: rtl/world_map_addr_gen.sv
// Pixel row/column -> world-map BRAM address via step counters; address 1 cycle, video_on 1+ALIGN_STAGES cycles.
// No backpressure (one pixel per clock). WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN also aligns hsync/vsync.
module world_map_addr_gen #(
  parameter int H_SCALE      = 8,
  parameter int V_SCALE      = 6,
  parameter int MAP_DIM      = world_map_pkg::MAP_DIM,
  parameter int ALIGN_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  world_map_addr_gen_if.slave bus
);
  import world_map_pkg::*;

  localparam int FW  = MAP_ADDR_W / 2;
  localparam int CW  = FW + 1;
  localparam int CSW = $clog2(H_SCALE);
  localparam int RSW = $clog2(V_SCALE);
  localparam int DLY = 1 + ALIGN_STAGES;
  localparam logic [CW-1:0] CNT_SAT = CW'(MAP_DIM);

  logic [CSW-1:0]        r_col_sub,     w_col_sub_nxt;
  logic [CW-1:0]         r_map_col_cnt, w_map_col_cnt_nxt;
  logic [RSW-1:0]        r_row_sub,     w_row_sub_nxt;
  logic [CW-1:0]         r_map_row_cnt, w_map_row_cnt_nxt;
  logic                  r_line_vld,    w_line_vld_nxt;
  logic                  r_video_d;
  logic [MAP_ADDR_W-1:0] r_vid_addr,    w_vid_addr_nxt;
  logic                  r_out_of_map,  w_out_of_map_nxt;

  logic          w_line_sync;
  logic          w_frame_sync;
  logic          w_eol;
  logic          w_active;
  logic [CW-1:0] w_col_eff;
  logic [CW-1:0] w_row_eff;

  function automatic logic [FW-1:0] sat_field(input logic [CW-1:0] cnt);
    return (cnt >= CNT_SAT) ? FW'(MAP_DIM - 1) : cnt[FW-1:0];
  endfunction

  assign w_line_sync  = bus.video_on && (bus.pixel_column == '0);
  assign w_frame_sync = w_line_sync && (bus.pixel_row == '0);
  // Only lines that were opened by a column-0 sync advance the row counter.
  assign w_eol        = r_video_d && !bus.video_on && r_line_vld;
  assign w_active     = bus.video_on && (w_line_sync || r_line_vld);
  assign w_col_eff    = w_line_sync  ? '0 : r_map_col_cnt;
  assign w_row_eff    = w_frame_sync ? '0 : r_map_row_cnt;

  always_comb begin
    w_col_sub_nxt     = r_col_sub;
    w_map_col_cnt_nxt = r_map_col_cnt;
    w_line_vld_nxt    = r_line_vld;
    if (w_line_sync) begin
      w_col_sub_nxt     = CSW'(1);
      w_map_col_cnt_nxt = '0;
      w_line_vld_nxt    = 1'b1;
    end else if (bus.video_on && r_line_vld) begin
      if (r_col_sub == CSW'(H_SCALE - 1)) begin
        w_col_sub_nxt = '0;
        if (r_map_col_cnt < CNT_SAT) w_map_col_cnt_nxt = r_map_col_cnt + CW'(1);
      end else begin
        w_col_sub_nxt = r_col_sub + CSW'(1);
      end
    end
  end

  always_comb begin
    w_row_sub_nxt     = r_row_sub;
    w_map_row_cnt_nxt = r_map_row_cnt;
    if (w_frame_sync) begin
      w_row_sub_nxt     = '0;
      w_map_row_cnt_nxt = '0;
    end else if (w_eol) begin
      if (r_row_sub == RSW'(V_SCALE - 1)) begin
        w_row_sub_nxt = '0;
        if (r_map_row_cnt < CNT_SAT) w_map_row_cnt_nxt = r_map_row_cnt + CW'(1);
      end else begin
        w_row_sub_nxt = r_row_sub + CSW'(0) + RSW'(1);
      end
    end
  end

  always_comb begin
    w_vid_addr_nxt   = r_vid_addr;
    w_out_of_map_nxt = 1'b1;
    if (w_active) begin
      w_vid_addr_nxt   = {sat_field(w_row_eff), sat_field(w_col_eff)};
      w_out_of_map_nxt = (w_row_eff >= CNT_SAT) || (w_col_eff >= CNT_SAT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_sub     <= '0;
      r_map_col_cnt <= '0;
      r_row_sub     <= '0;
      r_map_row_cnt <= '0;
      r_line_vld    <= 1'b0;
      r_video_d     <= 1'b0;
      r_vid_addr    <= '0;
      r_out_of_map  <= 1'b1;
    end else begin
      r_col_sub     <= w_col_sub_nxt;
      r_map_col_cnt <= w_map_col_cnt_nxt;
      r_row_sub     <= w_row_sub_nxt;
      r_map_row_cnt <= w_map_row_cnt_nxt;
      r_line_vld    <= w_line_vld_nxt;
      r_video_d     <= bus.video_on;
      r_vid_addr    <= w_vid_addr_nxt;
      r_out_of_map  <= w_out_of_map_nxt;
    end
  end

  assign bus.vid_addr   = r_vid_addr;
  assign bus.out_of_map = r_out_of_map;

  align_shift_reg #(
    .WIDTH   (1),
    .DEPTH   (DLY),
    .RST_VAL (1'b0)
  ) u_video_align (
    .clk   (clk),
    .reset (reset),
    .i_dat (bus.video_on),
    .o_dat (bus.video_on_aligned)
  );

`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
  logic [1:0] w_sync_aligned;

  // Syncs are active-low, so the delay line resets to the inactive level.
  align_shift_reg #(
    .WIDTH   (2),
    .DEPTH   (DLY),
    .RST_VAL (2'b11)
  ) u_sync_align (
    .clk   (clk),
    .reset (reset),
    .i_dat ({bus.hsync_in, bus.vsync_in}),
    .o_dat (w_sync_aligned)
  );

  assign bus.hsync_aligned = w_sync_aligned[1];
  assign bus.vsync_aligned = w_sync_aligned[0];
`endif

endmodule

// File: tb/tb_world_map_addr_gen.sv
// Randomized + directed bench for world_map_addr_gen against a pixel-count reference model.
// Model: map_col = min(pixels since line sync / H, MAP_DIM), map_row = min(synced lines since frame / V, MAP_DIM).
module tb_world_map_addr_gen;
  import world_map_pkg::*;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int MD = 128;
  localparam int AS = 2;

  logic clk = 1'b0;
  logic reset;

  world_map_addr_gen_if bus();

  world_map_addr_gen #(
    .H_SCALE      (H),
    .V_SCALE      (V),
    .MAP_DIM      (MD),
    .ALIGN_STAGES (AS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_k;
  bit          m_synced;
  int          m_lines;
  bit          m_prev_von;
  bit          m_vh [AS];
  logic [13:0] exp_addr;
  bit          exp_oom;
  bit          exp_al;

  bit          chk_en = 1'b0;
  bit          lit_addr_en = 1'b0, lit_oom_en = 1'b0, lit_al_en = 1'b0;
  logic [13:0] lit_addr;
  bit          lit_oom, lit_al;

`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
  bit drv_hs = 1'b1, drv_vs = 1'b1;
  bit m_hh [AS];
  bit m_vsh [AS];
  bit exp_hs, exp_vs;
  bit lit_hs_en = 1'b0;
  bit lit_hs;
`endif

  function automatic int satf(input int x);
    return (x >= MD) ? MD - 1 : x;
  endfunction

  task automatic model_step(input bit rst, input int row, input int col, input bit von);
    bit line_sync;
    int mc, mr;
    if (rst) begin
      m_k = 0; m_synced = 1'b0; m_lines = 0; m_prev_von = 1'b0;
      for (int j = 0; j < AS; j++) m_vh[j] = 1'b0;
      exp_addr = '0; exp_oom = 1'b1; exp_al = 1'b0;
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
      for (int j = 0; j < AS; j++) begin m_hh[j] = 1'b1; m_vsh[j] = 1'b1; end
      exp_hs = 1'b1; exp_vs = 1'b1;
`endif
      return;
    end
    line_sync = von && (col == 0);
    if (m_prev_von && !von && m_synced) m_lines++;
    if (line_sync && row == 0) m_lines = 0;
    if (line_sync) begin m_synced = 1'b1; m_k = 0; end
    if (von && m_synced) begin
      mc = m_k / H;
      mr = m_lines / V;
      exp_addr = {7'(satf(mr)), 7'(satf(mc))};
      exp_oom  = (mc >= MD) || (mr >= MD);
      m_k++;
    end else begin
      exp_oom = 1'b1;
    end
    m_prev_von = von;
    exp_al = m_vh[AS-1];
    for (int j = AS - 1; j > 0; j--) m_vh[j] = m_vh[j-1];
    m_vh[0] = von;
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
    exp_hs = m_hh[AS-1];
    exp_vs = m_vsh[AS-1];
    for (int j = AS - 1; j > 0; j--) begin m_hh[j] = m_hh[j-1]; m_vsh[j] = m_vsh[j-1]; end
    m_hh[0] = drv_hs;
    m_vsh[0] = drv_vs;
`endif
  endtask

  task automatic step(input bit rst, input int row, input int col, input bit von);
    reset = rst;
    bus.pixel_row    = 11'(row);
    bus.pixel_column = 11'(col);
    bus.video_on     = von;
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
    bus.hsync_in = drv_hs;
    bus.vsync_in = drv_vs;
`endif
    model_step(rst, row, col, von);
    @(posedge clk);
    @(negedge clk);
    #1;
    lit_addr_en = 1'b0; lit_oom_en = 1'b0; lit_al_en = 1'b0;
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
    lit_hs_en = 1'b0;
`endif
  endtask

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("vid_addr", 16'(bus.vid_addr), 16'(exp_addr));
      cmp("out_of_map", 16'(bus.out_of_map), 16'(exp_oom));
      cmp("video_on_aligned", 16'(bus.video_on_aligned), 16'(exp_al));
      if (lit_addr_en) cmp("lit_vid_addr", 16'(bus.vid_addr), 16'(lit_addr));
      if (lit_oom_en)  cmp("lit_out_of_map", 16'(bus.out_of_map), 16'(lit_oom));
      if (lit_al_en)   cmp("lit_video_on_aligned", 16'(bus.video_on_aligned), 16'(lit_al));
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
      cmp("hsync_aligned", 16'(bus.hsync_aligned), 16'(exp_hs));
      cmp("vsync_aligned", 16'(bus.vsync_aligned), 16'(exp_vs));
      if (lit_hs_en) cmp("lit_hsync_aligned", 16'(bus.hsync_aligned), 16'(lit_hs));
`endif
    end
  end

  task automatic blank(input int row, input int col0, input int n);
    for (int b = 0; b < n; b++) step(1'b0, row, col0 + b, 1'b0);
  endtask

  initial begin
    bit pat [9];
    int row, col, ncol;
    bit von, rst;

    pat[0] = 0; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0;
    pat[5] = 1; pat[6] = 0; pat[7] = 0; pat[8] = 0;

    chk_en = 1'b1;
    lit_addr_en = 1'b1; lit_addr = '0;
    lit_oom_en  = 1'b1; lit_oom  = 1'b1;
    lit_al_en   = 1'b1; lit_al   = 1'b0;
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
    lit_hs_en = 1'b1; lit_hs = 1'b1;
`endif
    step(1'b1, 0, 0, 1'b1);
    step(1'b1, 0, 0, 1'b1);

    // line 0: column field steps every 8 pixels
    for (int c = 0; c < 24; c++) begin
      lit_addr_en = 1'b1; lit_addr = {7'd0, 7'(c / 8)};
      lit_oom_en  = 1'b1; lit_oom  = 1'b0;
      step(1'b0, 0, c, 1'b1);
    end
    blank(0, 24, 4);
    for (int r = 1; r < 6; r++) begin
      ncol = 10 + int'($urandom_range(0, 30));
      for (int c = 0; c < ncol; c++) step(1'b0, r, c, 1'b1);
      blank(r, ncol, 3);
    end
    for (int c = 0; c < 21; c++) begin
      if (c == 16) begin
        lit_addr_en = 1'b1; lit_addr = {7'd1, 7'd2};
        lit_oom_en  = 1'b1; lit_oom  = 1'b0;
      end
      step(1'b0, 6, c, 1'b1);
    end
    blank(6, 21, 3);

    // column saturation on a 1030-pixel line
    for (int c = 0; c < 1030; c++) begin
      if (c == 1023 || c == 1024) begin
        lit_addr_en = 1'b1; lit_addr = {7'd1, 7'd127};
        lit_oom_en  = 1'b1; lit_oom  = (c == 1024);
      end
      step(1'b0, 7, c, 1'b1);
    end
    blank(7, 1030, 3);

    // video_on 1,0,1 reappears on video_on_aligned three cycles later
    for (int i = 0; i < 9; i++) begin
      if (i >= 2) begin lit_al_en = 1'b1; lit_al = pat[i-2]; end
      step(1'b0, 8, (i == 3) ? 0 : i + 20, pat[i]);
    end

    // reset in the middle of a line
    blank(0, 100, 2);
    for (int c = 0; c < 40; c++) step(1'b0, 0, c, 1'b1);
    lit_addr_en = 1'b1; lit_addr = '0; lit_oom_en = 1'b1; lit_oom = 1'b1;
    step(1'b1, 0, 40, 1'b1);
    for (int c = 41; c < 61; c++) begin
      lit_addr_en = 1'b1; lit_addr = '0; lit_oom_en = 1'b1; lit_oom = 1'b1;
      step(1'b0, 0, c, 1'b1);
    end
    blank(0, 61, 4);
    for (int c = 0; c < 30; c++) begin
      lit_addr_en = 1'b1; lit_addr = {7'd0, 7'(c / 8)};
      lit_oom_en  = 1'b1; lit_oom  = 1'b0;
      step(1'b0, 1, c, 1'b1);
    end
    blank(1, 30, 3);

`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
    // 96-cycle hsync low pulse
    for (int i = 0; i < 106; i++) begin
      drv_hs = !(i >= 3 && i < 99);
      if (i >= 2) begin lit_hs_en = 1'b1; lit_hs = !((i - 2) >= 3 && (i - 2) < 99); end
      step(1'b0, 2, i, 1'b0);
    end
    drv_hs = 1'b1;
`endif

    // randomized lines: column jumps, mid-line video_on drops, rare resets
    row = 0;
    for (int l = 0; l < 120; l++) begin
      ncol = int'($urandom_range(4, 80));
      col = ($urandom_range(0, 9) == 0) ? 3 : 0;
      for (int p = 0; p < ncol; p++) begin
        von = 1'b1;
        if ($urandom_range(0, 15) == 0) col += int'($urandom_range(1, 50));
        if ($urandom_range(0, 31) == 0) von = 1'b0;
        rst = ($urandom_range(0, 399) == 0);
`ifdef WORLD_MAP_ADDR_GEN_SYNC_DELAY_EN
        drv_hs = ($urandom_range(0, 3) != 0);
        drv_vs = ($urandom_range(0, 3) != 0);
`endif
        step(rst, row, col, von);
        col++;
      end
      blank(row, col, int'($urandom_range(1, 6)));
      row++;
      if ($urandom_range(0, 29) == 0) row = 0;
    end

    // row saturation over a tall frame of short lines
    for (int r = 0; r < 770; r++) begin
      for (int c = 0; c < 16; c++) begin
        if ((r == 767 || r == 768) && c == 0) begin
          lit_addr_en = 1'b1; lit_addr = {7'd127, 7'd0};
          lit_oom_en  = 1'b1; lit_oom  = (r == 768);
        end
        if (r == 769 && c == 9) begin
          lit_addr_en = 1'b1; lit_addr = {7'd127, 7'd1};
          lit_oom_en  = 1'b1; lit_oom  = 1'b1;
        end
        step(1'b0, r, c, 1'b1);
      end
      blank(r, 16, 2);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
